// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers, used by the sync
// generator and by the pixel generators that consume pix_x/pix_y.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_DISPLAY_D = 640;
    localparam int H_FP_D      = 16;
    localparam int H_SYNC_D    = 96;
    localparam int H_BP_D      = 48;
    localparam int V_DISPLAY_D = 480;
    localparam int V_FP_D      = 10;
    localparam int V_SYNC_D    = 2;
    localparam int V_BP_D      = 33;
    localparam int CLK_DIV_D   = 2;

    localparam int H_TOTAL = H_DISPLAY_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL = V_DISPLAY_D + V_FP_D + V_SYNC_D + V_BP_D;

    typedef logic [CNT_W-1:0] coord_t;

    // Inclusive window test, used for the sync pulse regions.
    function automatic logic in_window(coord_t pos, coord_t lo, coord_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter; max_tick is high while the count sits at M-1.
// With M=1 the count never moves and max_tick stays high.
module mod_m_counter #(
    parameter int M = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic max_tick
);

    localparam int           W    = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] count;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = (count == LAST) ? '0 : count + W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else          count <= count_next;
    end

    assign max_tick = (count == LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: pixel-rate strobe, scan counters, registered sync
// pulses aligned with the counters, and visible-area / end-of-frame decode.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_D,
    parameter int H_FP      = H_FP_D,
    parameter int H_SYNC    = H_SYNC_D,
    parameter int H_BP      = H_BP_D,
    parameter int V_DISPLAY = V_DISPLAY_D,
    parameter int V_FP      = V_FP_D,
    parameter int V_SYNC    = V_SYNC_D,
    parameter int V_BP      = V_BP_D,
    parameter int CLK_DIV   = CLK_DIV_D
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             p_tick,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_tick
);

    localparam int H_TOT = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = CNT_W'(H_TOT - 1);
    localparam coord_t V_LAST   = CNT_W'(V_TOT - 1);
    localparam coord_t H_VIS    = CNT_W'(H_DISPLAY);
    localparam coord_t V_VIS    = CNT_W'(V_DISPLAY);
    localparam coord_t V_VIS_LAST = CNT_W'(V_DISPLAY - 1);
    localparam coord_t HS_START = CNT_W'(H_DISPLAY + H_FP);
    localparam coord_t HS_END   = CNT_W'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = CNT_W'(V_DISPLAY + V_FP);
    localparam coord_t VS_END   = CNT_W'(V_DISPLAY + V_FP + V_SYNC - 1);

    coord_t x_next;
    coord_t y_next;

    mod_m_counter #(.M(CLK_DIV)) u_pix_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .max_tick (p_tick)
    );

    // NOTE: every variable assigned in always_comb gets a default first,
    // otherwise a missed branch infers a latch.
    always_comb begin
        x_next = pix_x;
        y_next = pix_y;
        if (p_tick) begin
            if (pix_x == H_LAST) begin
                x_next = '0;
                y_next = (pix_y == V_LAST) ? '0 : pix_y + CNT_W'(1);
            end else begin
                x_next = pix_x + CNT_W'(1);
            end
        end
    end

    // Sync flops look at the next-state counters so they change in the same
    // clk as pix_x/pix_y rather than one pixel late.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_x <= '0;
            pix_y <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            pix_x <= x_next;
            pix_y <= y_next;
            hsync <= !in_window(x_next, HS_START, HS_END);
            vsync <= !in_window(y_next, VS_START, VS_END);
        end
    end

    assign video_on   = (pix_x < H_VIS) && (pix_y < V_VIS);
    assign frame_tick = p_tick && (pix_x == H_LAST) && (pix_y == V_VIS_LAST);

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync: a default-timing instance for line-level
// behaviour and a shrunken-timing instance for whole-frame behaviour.
module tb_vga_sync;

    typedef struct packed {
        logic       hs, vs, vo, pt, ft;
        logic [9:0] x, y;
    } snap_t;

    typedef struct {
        int hd, hfp, hs, hbp, vd, vfp, vs, vbp, div;
    } tim_t;

    // Shrunken timing: 25 pixels x 17 lines, 3 clks per pixel.
    localparam int B_HD = 16, B_HFP = 2, B_HS = 3, B_HBP = 4;
    localparam int B_VD = 10, B_VFP = 2, B_VS = 2, B_VBP = 3;
    localparam int B_DIV = 3;

    logic clk = 1'b0;
    logic ra  = 1'b0;
    logic rb  = 1'b0;

    logic       a_hs, a_vs, a_vo, a_pt, a_ft;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_vo, b_pt, b_ft;
    logic [9:0] b_x, b_y;

    int     checks = 0;
    int     errors = 0;
    longint ka = 0;
    longint kb = 0;
    tim_t   pa, pb;

    always #5 clk = ~clk;

    vga_sync dut_a (
        .clk(clk), .reset_n(ra), .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
        .p_tick(a_pt), .pix_x(a_x), .pix_y(a_y), .frame_tick(a_ft)
    );

    vga_sync #(
        .H_DISPLAY(B_HD), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_DISPLAY(B_VD), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .CLK_DIV(B_DIV)
    ) dut_b (
        .clk(clk), .reset_n(rb), .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
        .p_tick(b_pt), .pix_x(b_x), .pix_y(b_y), .frame_tick(b_ft)
    );

    // Expected outputs k clk edges after reset release: the pixel index is
    // k / div, mapped onto a raster of ht x vt positions.
    function automatic snap_t model(tim_t p, longint k, bit in_reset);
        snap_t  s;
        int     ht, vt, pos, x, y;
        longint n;
        ht = p.hd + p.hfp + p.hs + p.hbp;
        vt = p.vd + p.vfp + p.vs + p.vbp;
        if (in_reset) begin
            s = '{hs: 1'b1, vs: 1'b1, vo: 1'b1, pt: 1'b0, ft: 1'b0, x: 10'd0, y: 10'd0};
            return s;
        end
        n    = k / p.div;
        pos  = int'(n % longint'(ht * vt));
        x    = pos % ht;
        y    = pos / ht;
        s.x  = 10'(x);
        s.y  = 10'(y);
        s.pt = ((k % p.div) == p.div - 1);
        s.hs = !(x >= p.hd + p.hfp && x < p.hd + p.hfp + p.hs);
        s.vs = !(y >= p.vd + p.vfp && y < p.vd + p.vfp + p.vs);
        s.vo = (x < p.hd) && (y < p.vd);
        s.ft = s.pt && (x == ht - 1) && (y == p.vd - 1);
        return s;
    endfunction

    function automatic snap_t obs_a();
        snap_t s;
        s = '{hs: a_hs, vs: a_vs, vo: a_vo, pt: a_pt, ft: a_ft, x: a_x, y: a_y};
        return s;
    endfunction

    function automatic snap_t obs_b();
        snap_t s;
        s = '{hs: b_hs, vs: b_vs, vo: b_vo, pt: b_pt, ft: b_ft, x: b_x, y: b_y};
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("(x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b ft=%b)",
                         s.x, s.y, s.hs, s.vs, s.vo, s.pt, s.ft);
    endfunction

    // One clk: count edges seen while out of reset, then settle at negedge.
    task automatic tick_clk();
        @(posedge clk);
        ka = ra ? ka + 1 : 0;
        kb = rb ? kb + 1 : 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        snap_t o, e;
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            e = model(pa, 0, 1'b1);
            o = obs_a();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_a got %s want %s", fmt(o), fmt(e));
            end
            o = obs_b();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_b got %s want %s", fmt(o), fmt(e));
            end
        end
        ra = 1'b1;
    endtask

    task automatic test_tick();
        snap_t o, e;
        int    ticks = 0;
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            o = obs_a();
            e = model(pa, ka, 1'b0);
            if (o.pt) ticks++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL tick k=%0d got %s want %s", ka, fmt(o), fmt(e));
            end
            if (ka == 1 || ka == 2) begin
                checks++;
                if (o.x !== 10'(ka - 1) || o.pt !== (ka == 1)) begin
                    errors++;
                    $display("FAIL first_advance k=%0d got x=%0d pt=%b want x=%0d pt=%b",
                             ka, o.x, o.pt, ka - 1, ka == 1);
                end
            end
        end
        checks++;
        if (ticks != 5) begin
            errors++;
            $display("FAIL tick_rate got %0d ticks want 5 in 10 clks", ticks);
        end
    endtask

    task automatic test_line();
        snap_t o, e;
        logic  prev_vo = 1'b1;
        int    fall_x = -1, hs_ticks = 0, hs_first = -1, hs_last = -1;
        while (ka < 3 * 1600 + 10) begin
            tick_clk();
            o = obs_a();
            e = model(pa, ka, 1'b0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL line k=%0d got %s want %s", ka, fmt(o), fmt(e));
            end
            if (o.y == 0) begin
                if (prev_vo && !o.vo && fall_x < 0) fall_x = int'(o.x);
                if (!o.hs && o.pt) begin
                    hs_ticks++;
                    if (hs_first < 0) hs_first = int'(o.x);
                    hs_last = int'(o.x);
                end
            end
            prev_vo = o.vo;
            if (ka == 1599 || ka == 1600) begin
                checks++;
                if (o.x !== (ka == 1599 ? 10'd799 : 10'd0) || o.y !== (ka == 1599 ? 10'd0 : 10'd1)) begin
                    errors++;
                    $display("FAIL line_wrap k=%0d got (%0d,%0d)", ka, o.x, o.y);
                end
            end
        end
        checks++;
        if (fall_x != 640) begin
            errors++;
            $display("FAIL video_off_x got %0d want 640", fall_x);
        end
        checks++;
        if (hs_ticks != 96 || hs_first != 656 || hs_last != 751) begin
            errors++;
            $display("FAIL hsync_window got %0d ticks [%0d,%0d] want 96 [656,751]",
                     hs_ticks, hs_first, hs_last);
        end
    endtask

    // Random run lengths followed by an async reset dropped between edges.
    task automatic test_random_reset_a();
        snap_t o, e;
        int    run, d;
        for (int it = 0; it < 3; it++) begin
            run = int'($urandom_range(1, 4000));
            for (int i = 0; i < run; i++) begin
                tick_clk();
                o = obs_a();
                e = model(pa, ka, 1'b0);
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL rand_run it=%0d k=%0d got %s want %s", it, ka, fmt(o), fmt(e));
                end
            end
            d = int'($urandom_range(1, 3));
            #(d);
            ra = 1'b0;
            #1;
            o = obs_a();
            e = model(pa, 0, 1'b1);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rand_reset it=%0d got %s want %s", it, fmt(o), fmt(e));
            end
            repeat (int'($urandom_range(1, 3))) tick_clk();
            ra = 1'b1;
        end
    endtask

    task automatic test_frame();
        snap_t o, e;
        logic  prev_ft = 1'b0;
        int    pulses = 0, vs_ticks = 0;
        int    frame_clks = 25 * 17 * B_DIV;
        rb = 1'b1;
        while (kb < 2 * frame_clks + 20) begin
            tick_clk();
            o = obs_b();
            e = model(pb, kb, 1'b0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL frame k=%0d got %s want %s", kb, fmt(o), fmt(e));
            end
            if (!o.vs && o.pt && kb < frame_clks) vs_ticks++;
            if (o.ft) begin
                pulses++;
                checks++;
                if (prev_ft || o.x != 10'd24 || o.y != 10'd9) begin
                    errors++;
                    $display("FAIL frame_tick_pos got (%0d,%0d) prev=%b want (24,9) prev=0",
                             o.x, o.y, prev_ft);
                end
            end
            prev_ft = o.ft;
            if (kb == frame_clks - 1 || kb == frame_clks) begin
                checks++;
                if (o.x !== (kb == frame_clks ? 10'd0 : 10'd24) || o.y !== (kb == frame_clks ? 10'd0 : 10'd16)) begin
                    errors++;
                    $display("FAIL frame_wrap k=%0d got (%0d,%0d)", kb, o.x, o.y);
                end
            end
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL frame_tick_count got %0d want 2", pulses);
        end
        checks++;
        if (vs_ticks != 2 * 25) begin
            errors++;
            $display("FAIL vsync_ticks got %0d want 50", vs_ticks);
        end
    endtask

    task automatic test_async_reset();
        snap_t  o, e;
        longint stop;
        rb = 1'b0;
        tick_clk();
        rb = 1'b1;
        stop = longint'((8 * 25 + 15) * B_DIV) + longint'($urandom_range(0, 2));
        while (kb < stop) tick_clk();
        o = obs_b();
        checks++;
        if (o.x !== 10'd15 || o.y !== 10'd8) begin
            errors++;
            $display("FAIL pre_reset_pos got (%0d,%0d) want (15,8)", o.x, o.y);
        end
        #(int'($urandom_range(1, 3)));
        rb = 1'b0;
        #1;
        o = obs_b();
        e = model(pb, 0, 1'b1);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL async_reset got %s want %s", fmt(o), fmt(e));
        end
        repeat (2) tick_clk();
        rb = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick_clk();
            o = obs_b();
            e = model(pb, kb, 1'b0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL restart k=%0d got %s want %s", kb, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        pa = '{hd: 640, hfp: 16, hs: 96, hbp: 48, vd: 480, vfp: 10, vs: 2, vbp: 33, div: 2};
        pb = '{hd: B_HD, hfp: B_HFP, hs: B_HS, hbp: B_HBP,
               vd: B_VD, vfp: B_VFP, vs: B_VS, vbp: B_VBP, div: B_DIV};
        test_reset();
        test_tick();
        test_line();
        test_random_reset_a();
        test_frame();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
